shift_deserializer: RTL and testbench
=====================================

// Module: shift_deserializer
// PURPOSE
//   Receive-side counterpart of the mixed serializer: collects a 1-bit serial stream into WIDTH-bit words.
//   Sits at the link input, feeding parallel words to the core over a valid/ready handshake.
//   Single clock domain; the core clock is used directly, with no internal clock division.
//   Bit order matches the serializer: LSB first.
// PARAMETERS
//   WIDTH     8                 parallel word width, >=2
//   LOGWIDTH  $clog2(WIDTH)     bit-counter width
// PORTS
//   clk           in   1      clock, rising edge
//   reset         in   1      asynchronous, active-high
//   data_i        in   1      serial bit, sampled only when valid_i=1
//   valid_i       in   1      serial bit qualifier
//   align_i       in   1      frame alignment: next accepted bit is bit 0
//   data_o        out  WIDTH  assembled word, stable while valid_o=1
//   valid_o       out  1      output word held
//   ready_i       in   1      consumer accepts data_o when valid_o&&ready_i
//   overflow_o    out  1      sticky: a completed word was dropped
//   parity_err_o  out  1      parity mismatch on the held word (0 without the macro)
// BEHAVIOUR
//   Reset (async, any time, including mid-word):
//     - data_o=0, valid_o=0, overflow_o=0, parity_err_o=0, counter=0, FSM=IDLE.
//     - A partial word is discarded.
//   Datapath:
//     - WIDTH-bit shift register; accepted bit k (k=0..WIDTH-1) is written to position k.
//     - Output holding register drives data_o.
//   FSM: IDLE -> SHIFT on the first accepted bit; SHIFT -> IDLE after bit WIDTH-1
//     (-> PARITY when DESER_PARITY_EN; PARITY -> IDLE on the accepted parity bit).
//   Counter: increments only on valid_i=1; gaps of any length are allowed; wraps to 0 at word end.
//   Completion (last bit accepted in cycle N):
//     - Word loads into the holding register at the edge ending cycle N.
//     - valid_o=1 from cycle N+1 (latency 1).
//   Handshake:
//     - valid_o stays high and data_o stays stable until valid_o&&ready_i.
//     - valid_o drops the following cycle unless a new word completes in the same cycle.
//   Simultaneous completion and consume: the new word loads and valid_o stays 1; no overflow.
//   Completion while holding and ready_i=0: the new word is dropped, data_o is unchanged,
//     overflow_o=1 until reset.
//   align_i=1:
//     - Counter clears and the FSM goes to IDLE; the partial word is discarded.
//     - If valid_i=1 in the same cycle, that bit is taken as bit 0.
//     - The holding register is unaffected.
//   ready_i has no effect while valid_o=0.
// CONFIGURATION
//   DESER_PARITY_EN defined:
//     - Each word is followed by one even-parity bit, the (WIDTH+1)th accepted bit.
//     - Completion is on the parity bit.
//     - parity_err_o = (^word)^parity, loaded and held together with data_o.
//     - A word with bad parity is still delivered.
//   Undefined:
//     - No PARITY state; words are exactly WIDTH bits.
//     - parity_err_o is tied to 0.
// TESTING (WIDTH=8)
//   1. Bits 1,0,1,0,0,1,0,1 on consecutive cycles, ready_i=1
//      -> data_o=0xA5, valid_o=1 for exactly one cycle, in the cycle after bit 7.
//   2. Same bits with valid_i gaps of 0-3 idle cycles -> data_o=0xA5; no intermediate valid_o.
//   3. ready_i=0; send 0x3C then 0xFF
//      -> data_o stays 0x3C, overflow_o=1; after ready_i=1, valid_o drops.
//   4. Send 3 bits, align_i with valid_i, then 8 bits of 0x81
//      -> data_o=0x81; the partial word never appears.
//   5. Assert reset after 5 bits of a word with valid_o=1
//      -> all outputs 0 immediately; the next full word 0x5A is received correctly.
//   6. DESER_PARITY_EN: send 0x07 with parity 1 -> parity_err_o=0;
//      send 0x07 with parity 0 -> parity_err_o=1, data_o=0x07.

Source files
------------

// File: rtl/shift_deserializer.sv
// LSB-first serial-to-parallel receiver with a one-word valid/ready output holding register.
// Define DESER_PARITY_EN to expect a trailing even-parity bit after each word.
module shift_deserializer #(
    parameter int WIDTH    = 8,
    parameter int LOGWIDTH = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_i,
    input  logic             valid_i,
    input  logic             align_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overflow_o,
    output logic             parity_err_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t              r_state, w_state_nxt, w_state_cur;
    logic [LOGWIDTH-1:0] r_cnt, w_cnt_nxt, w_idx;
    logic [WIDTH-1:0]    r_shift, w_shift_nxt, w_word, r_data;
    logic                r_valid, r_ovf;
    logic                w_complete, w_load;
`ifdef DESER_PARITY_EN
    logic                w_perr, r_perr;
`endif

    // align_i overrides the current frame position before the incoming bit is placed
    always_comb begin
        w_state_cur = align_i ? IDLE : r_state;
        w_idx       = align_i ? '0 : r_cnt;
        w_state_nxt = w_state_cur;
        w_cnt_nxt   = w_idx;
        w_shift_nxt = r_shift;
        w_word      = r_shift;
        w_complete  = 1'b0;
`ifdef DESER_PARITY_EN
        w_perr      = 1'b0;
`endif
        if (valid_i) begin
            case (w_state_cur)
                IDLE, SHIFT: begin
                    w_shift_nxt[w_idx] = data_i;
                    if (w_idx == LOGWIDTH'(WIDTH-1)) begin
                        w_cnt_nxt = '0;
`ifdef DESER_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = IDLE;
                        w_complete  = 1'b1;
                        w_word      = w_shift_nxt;
`endif
                    end else begin
                        w_cnt_nxt   = w_idx + LOGWIDTH'(1);
                        w_state_nxt = SHIFT;
                    end
                end
`ifdef DESER_PARITY_EN
                PARITY: begin
                    w_state_nxt = IDLE;
                    w_complete  = 1'b1;
                    w_word      = r_shift;
                    w_perr      = (^r_shift) ^ data_i;
                end
`endif
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // A completed word is only accepted if the holding register is empty or being drained
    assign w_load = w_complete && (!r_valid || ready_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            if (w_load) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_complete && !w_load)
                r_ovf <= 1'b1;
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_perr <= 1'b0;
        else if (w_load)
            r_perr <= w_perr;
    end
    assign parity_err_o = r_perr;
`else
    assign parity_err_o = 1'b0;
`endif

    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign overflow_o = r_ovf;
endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer (WIDTH=8): directed scenarios plus a
// randomized run compared against a bit-queue reference model.
module tb_shift_deserializer;
    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam int NBITS = W + 1;
`else
    localparam int NBITS = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         data_i = 1'b0, valid_i = 1'b0, align_i = 1'b0, ready_i = 1'b0;
    logic [W-1:0] data_o;
    logic         valid_o, overflow_o, parity_err_o;

    int total = 0;
    int bad = 0;

    bit           m_q[$];
    logic         m_valid = 1'b0, m_ovf = 1'b0, m_perr = 1'b0;
    logic [W-1:0] m_data = '0;

    shift_deserializer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .align_i(align_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .overflow_o(overflow_o), .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic sbit(input logic [W-1:0] w, input int k);
        return (k < W) ? w[k] : ^w;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_valid = 1'b0; m_ovf = 1'b0; m_perr = 1'b0; m_data = '0;
    endtask

    // Drive one cycle, advance the reference model at the edge, return 1 time unit later
    task automatic step(input logic v, input logic d, input logic a, input logic r);
        logic         comp;
        logic         pe;
        logic [W-1:0] w;
        valid_i = v; data_i = d; align_i = a; ready_i = r;
        @(posedge clk);
        comp = 1'b0; pe = 1'b0; w = '0;
        if (a) m_q.delete();
        if (v) begin
            m_q.push_back(d);
            if (m_q.size() == NBITS) begin
                for (int k = 0; k < W; k++) if (m_q[k]) w = w + (W'(1) << k);
`ifdef DESER_PARITY_EN
                pe = (^w) ^ m_q[W];
`endif
                comp = 1'b1;
                m_q.delete();
            end
        end
        if (comp) begin
            if (!m_valid || r) begin
                m_valid = 1'b1; m_data = w; m_perr = pe;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        valid_i = 1'b0; align_i = 1'b0; ready_i = 1'b0; data_i = 1'b0;
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic r);
        for (int k = 0; k < NBITS; k++) step(1'b1, sbit(w, k), 1'b0, r);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (data_o !== '0 || valid_o !== 1'b0 || overflow_o !== 1'b0 || parity_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: data=%h valid=%b ovf=%b perr=%b, required 00 0 0 0",
                     data_o, valid_o, overflow_o, parity_err_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int k = 0; k < NBITS; k++) begin
            step(1'b1, sbit(8'hA5, k), 1'b0, 1'b1);
            if (k < NBITS - 1) begin
                total++;
                if (valid_o !== 1'b0) begin
                    bad++; $display("FAIL basic_early_valid bit%0d: valid=%b required 0", k, valid_o);
                end
            end
        end
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
            bad++; $display("FAIL basic_word: valid=%b data=%h required 1 a5", valid_o, data_o);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (valid_o !== 1'b0) begin
            bad++; $display("FAIL basic_one_cycle: valid=%b required 0", valid_o);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int k = 0; k < NBITS; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0, 1'b1);
            total++;
            if (valid_o !== 1'b0) begin
                bad++; $display("FAIL gaps_early_valid bit%0d: valid=%b required 0", k, valid_o);
            end
            step(1'b1, sbit(8'hA5, k), 1'b0, 1'b1);
        end
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
            bad++; $display("FAIL gaps_word: valid=%b data=%h required 1 a5", valid_o, data_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_word(8'h3C, 1'b0);
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'h3C || overflow_o !== 1'b0) begin
            bad++; $display("FAIL ovf_first: valid=%b data=%h ovf=%b required 1 3c 0", valid_o, data_o, overflow_o);
        end
        send_word(8'hFF, 1'b0);
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'h3C || overflow_o !== 1'b1) begin
            bad++; $display("FAIL ovf_drop: valid=%b data=%h ovf=%b required 1 3c 1", valid_o, data_o, overflow_o);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            bad++; $display("FAIL ovf_drain: valid=%b ovf=%b required 0 1", valid_o, overflow_o);
        end
    endtask

    task automatic test_align();
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < NBITS; k++) begin
            step(1'b1, sbit(8'h81, k), (k == 0) ? 1'b1 : 1'b0, 1'b1);
            if (k < NBITS - 1) begin
                total++;
                if (valid_o !== 1'b0) begin
                    bad++; $display("FAIL align_partial bit%0d: valid=%b data=%h required valid 0", k, valid_o, data_o);
                end
            end
        end
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'h81) begin
            bad++; $display("FAIL align_word: valid=%b data=%h required 1 81", valid_o, data_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(8'h33, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        total++;
        if (valid_o !== 1'b1) begin
            bad++; $display("FAIL midreset_hold: valid=%b required 1", valid_o);
        end
        reset = 1'b1;
        model_clear();
        #2;
        total++;
        if (data_o !== '0 || valid_o !== 1'b0 || overflow_o !== 1'b0 || parity_err_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async: data=%h valid=%b ovf=%b perr=%b required 00 0 0 0",
                     data_o, valid_o, overflow_o, parity_err_o);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        send_word(8'h5A, 1'b1);
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'h5A) begin
            bad++; $display("FAIL midreset_next: valid=%b data=%h required 1 5a", valid_o, data_o);
        end
    endtask

`ifdef DESER_PARITY_EN
    task automatic test_parity();
        do_reset();
        for (int k = 0; k < W; k++) step(1'b1, sbit(8'h07, k), 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'h07 || parity_err_o !== 1'b0) begin
            bad++; $display("FAIL parity_good: valid=%b data=%h perr=%b required 1 07 0", valid_o, data_o, parity_err_o);
        end
        for (int k = 0; k < W; k++) step(1'b1, sbit(8'h07, k), 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (valid_o !== 1'b1 || data_o !== 8'h07 || parity_err_o !== 1'b1) begin
            bad++; $display("FAIL parity_bad: valid=%b data=%h perr=%b required 1 07 1", valid_o, data_o, parity_err_o);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic v, d, a, r;
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            a = ($urandom_range(0, 39) == 0);
            r = (n % 200 < 150) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            step(v, d, a, r);
            total++;
            if (valid_o !== m_valid || overflow_o !== m_ovf || parity_err_o !== m_perr ||
                (m_valid && data_o !== m_data)) begin
                bad++;
                $display("FAIL random cyc%0d: valid=%b data=%h ovf=%b perr=%b required %b %h %b %b",
                         n, valid_o, data_o, overflow_o, parity_err_o, m_valid, m_data, m_ovf, m_perr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_align();
        test_reset_mid();
`ifdef DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
